tdm_demux_8: RTL
================

# tdm_demux_8

Eight-channel time-division demultiplexer: the receive-side counterpart of the team's 8:1 mux tree. A serial stream of WIDTH-bit samples, framed by a sync marker on slot 0, is split back into eight channels. Each sample goes out immediately on a per-slot strobe, and the whole frame is also presented as one parallel word. The block sits directly after the serialised link that carries a muxed bus.

## Interface
- WIDTH, 1: bits per sample/slot.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  WIDTH  serial sample for the current slot.
- din_valid  in  1  din carries a sample this cycle.
- frame_sync  in  1  qualified by din_valid; marks the sample as slot 0.
- ch_data  out  WIDTH  registered copy of last accepted sample.
- ch_strobe  out  8  one-hot, bit k = sample for slot k on ch_data (one cycle).
- dout  out  8*WIDTH  last complete frame; slot k at dout[k*WIDTH +: WIDTH].
- dout_valid  out  1  one-cycle pulse, new frame on dout.
- sync_err  out  1  one-cycle pulse on framing violation.
- locked  out  1  high in LOCKED state.

## Operation
- States: HUNT (reset state), LOCKED. slot counter 3 bits; frame shadow buffer 8*WIDTH.
- Beat = cycle with din_valid=1. Non-beats change nothing (no strobe, counter holds).
- HUNT: beats without frame_sync are discarded. A beat with frame_sync is taken as slot 0: shadow[0] written, strobe bit 0, slot to 1, state to LOCKED.
- LOCKED, slot k beat without sync (k≠0): shadow[k] written, ch_strobe[k], slot to k+1 (7 wraps to 0).
- LOCKED, slot 0 beat with sync: normal slot-0 handling.
- LOCKED, sync on slot k≠0: sync_err pulse, partial frame discarded, beat treated as new slot 0, slot to 1, stay LOCKED.
- LOCKED, slot 0 beat without sync: sync_err pulse, beat discarded (no strobe), state to HUNT.
- Slot-7 beat completes the frame: dout is loaded with shadow[0..6] plus the slot-7 sample in one register update, and dout_valid pulses. dout holds until the next complete frame.
- Discarded partial frames never reach dout.

## Timing
- Reset values: ch_data=0, ch_strobe=0, dout=0, dout_valid=0, sync_err=0, locked=0, slot=0, state HUNT, shadow=0.
- Reset mid-frame: outputs clear immediately (async); first accepted frame needs fresh sync.
- Latency: beat at edge N → ch_data/ch_strobe valid after edge N (visible cycle N+1), one cycle wide.
- Slot-7 beat at edge N → dout/dout_valid updated at edge N; dout_valid coincides with ch_strobe[7].
- sync_err asserts in the same cycle as the effect of the offending beat.
- locked reflects the state register; it rises together with ch_strobe[0] of the first synced beat.
- Back-to-back beats every cycle supported: full throughput, one sample per clock, no stall.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - Adds input din_par (1 bit). Even parity over {din, din_par} is checked per beat.
  - A mismatch pulses the added output par_err in the same cycle as the strobe. The sample is still strobed.
  - The current frame is marked bad. A bad frame does not load dout or pulse dout_valid. The mark clears at frame start.
- Not defined: no din_par/par_err ports, no checking; behaviour as above.

## Test plan
- Reset then 8 beats, sync on first, din=0..7 (WIDTH=4): ch_strobe walks 0x01..0x80; dout=0x76543210 with dout_valid on 8th beat; locked=1 from beat 1.
- Beats without sync after reset (din=0xF ×5): no strobes, locked=0, dout=0. Then sync beat: ch_strobe=0x01, locked=1.
- din_valid toggled 1/0 across a frame: strobes only on valid cycles; dout_valid after the 8th valid beat only.
- Sync on slot 3 while locked: sync_err pulse, ch_strobe=0x01. Next 7 beats (din=1..7) give dout=0x7654321x with slot 0 = resync sample; old partial frame is never output.
- Slot-0 beat without sync while locked: sync_err pulse, no strobe, locked falls. Following sync frame locks and delivers normally.
- rst_n low after slot 4: all outputs 0 asynchronously, HUNT. With TDM_DEMUX_PARITY_EN, a bad parity on slot 2 gives par_err and no dout_valid for that frame, while the next good frame gives dout_valid.

Source files
------------

// File: rtl/tdm_demux_8_if.sv
// tdm_demux_8_if: serial sample bus into tdm_demux_8 and its demuxed outputs; din_par/par_err exist only with TDM_DEMUX_PARITY_EN
interface tdm_demux_8_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_sync;
  logic [WIDTH-1:0]   ch_data;
  logic [7:0]         ch_strobe;
  logic [8*WIDTH-1:0] dout;
  logic               dout_valid;
  logic               sync_err;
  logic               locked;
`ifdef TDM_DEMUX_PARITY_EN
  logic               din_par;
  logic               par_err;
  modport master (output din, din_valid, frame_sync, din_par,
                  input ch_data, ch_strobe, dout, dout_valid, sync_err, locked, par_err);
  modport slave  (input din, din_valid, frame_sync, din_par,
                  output ch_data, ch_strobe, dout, dout_valid, sync_err, locked, par_err);
`else
  modport master (output din, din_valid, frame_sync,
                  input ch_data, ch_strobe, dout, dout_valid, sync_err, locked);
  modport slave  (input din, din_valid, frame_sync,
                  output ch_data, ch_strobe, dout, dout_valid, sync_err, locked);
`endif
endinterface

// File: rtl/tdm_demux_8.sv
// tdm_demux_8: 8-slot TDM demultiplexer with sync hunt/lock; TDM_DEMUX_PARITY_EN adds per-beat even parity and bad-frame suppression
module tdm_demux_8 #(parameter int WIDTH = 1) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  tdm_demux_8_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t             r_state, w_state_nxt;
  logic [2:0]         r_slot, w_slot_nxt, w_idx;
  logic               w_accept, w_err, w_bad;
  logic [8*WIDTH-1:0] r_shadow, r_dout;
  logic [WIDTH-1:0]   r_ch_data;
  logic [7:0]         r_ch_strobe;
  logic               r_dout_valid, r_sync_err;

  // framing decision for the current beat: which slot it lands in, whether it is kept, and state/slot advance
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_idx       = bus.frame_sync ? 3'd0 : r_slot;
    if (bus.din_valid) begin
      if (r_state == HUNT) begin
        w_accept    = bus.frame_sync;
        w_state_nxt = bus.frame_sync ? LOCKED : HUNT;
      end else begin
        w_accept    = bus.frame_sync | (r_slot != 3'd0);
        w_err       = bus.frame_sync ? (r_slot != 3'd0) : (r_slot == 3'd0);
        w_state_nxt = (!bus.frame_sync && r_slot == 3'd0) ? HUNT : LOCKED;
      end
    end
    w_slot_nxt = w_accept ? w_idx + 3'd1 : r_slot;
  end

  // state and slot registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
      r_slot  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // per-slot strobe, shadow capture and whole-frame publish on the slot-7 beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow     <= '0;
      r_dout       <= '0;
      r_ch_data    <= '0;
      r_ch_strobe  <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      if (w_accept) r_shadow[w_idx*WIDTH +: WIDTH] <= bus.din;
      if (w_accept) r_ch_data <= bus.din;
      if (w_accept && w_idx == 3'd7 && !w_bad) r_dout <= {bus.din, r_shadow[7*WIDTH-1:0]};
      r_ch_strobe  <= w_accept ? (8'd1 << w_idx) : 8'd0;
      r_dout_valid <= w_accept && w_idx == 3'd7 && !w_bad;
      r_sync_err   <= w_err;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic r_bad, r_par_err, w_perr;
  assign w_perr = ^{bus.din, bus.din_par};
  assign w_bad  = ((w_idx == 3'd0) ? 1'b0 : r_bad) | w_perr;
  // bad-frame mark restarts at slot 0 and accumulates parity errors of kept beats
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bad     <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_bad     <= w_accept ? w_bad : r_bad;
      r_par_err <= w_accept & w_perr;
    end
  end
  assign bus.par_err = r_par_err;
`else
  assign w_bad = 1'b0;
`endif

  assign bus.ch_data    = r_ch_data;
  assign bus.ch_strobe  = r_ch_strobe;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.sync_err   = r_sync_err;
  assign bus.locked     = (r_state == LOCKED);
endmodule
